// File: rtl/message_dumper.sv
// Streams one UART frame: six hex digits of the latched key, ':', MSG_LEN bytes
// read from the decrypted RAM, then CR LF. 8N1, LSB first, idle high.
module message_dumper #(
  parameter int MSG_LEN      = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_dump,
  input  logic [21:0] secret_key,
  output logic [7:0]  ram_address,
  input  logic [7:0]  ram_q,
  output logic        uart_tx,
  output logic        busy,
  output logic        done_dump
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [8:0] MSG_FIRST = 9'd7;
  localparam logic [8:0] CR_IDX    = 9'(7 + MSG_LEN);
  localparam logic [8:0] LF_IDX    = 9'(8 + MSG_LEN);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RAM, START_BIT, DATA_BITS, STOP_BIT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       char_idx_q, char_idx_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             wait_q, wait_d;
  logic [7:0]       shift_q, shift_d;
  logic [21:0]      key_q, key_d;
  logic [7:0]       ram_address_q, ram_address_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [23:0]      key_ext;
  logic [3:0]       nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign key_ext = {2'b00, key_q};

  always_comb begin
    case (char_idx_q[2:0])
      3'd0:    nib = key_ext[23:20];
      3'd1:    nib = key_ext[19:16];
      3'd2:    nib = key_ext[15:12];
      3'd3:    nib = key_ext[11:8];
      3'd4:    nib = key_ext[7:4];
      3'd5:    nib = key_ext[3:0];
      default: nib = 4'h0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    char_idx_d    = char_idx_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    wait_d        = wait_q;
    shift_d       = shift_q;
    key_d         = key_q;
    ram_address_d = ram_address_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_dump) begin
          state_d    = FETCH;
          key_d      = secret_key;
          busy_d     = 1'b1;
          char_idx_d = 9'd0;
        end
      end
      FETCH: begin
        bit_cnt_d = '0;
        bit_idx_d = 3'd0;
        // Message bytes take a detour through the RAM; everything else is a constant or key digit.
        if (char_idx_q >= MSG_FIRST && char_idx_q < CR_IDX) begin
          ram_address_d = 8'(char_idx_q - MSG_FIRST);
          wait_d        = 1'b0;
          state_d       = WAIT_RAM;
        end else begin
          if (char_idx_q < 9'd6)
            shift_d = hex_ascii(nib);
          else if (char_idx_q == 9'd6)
            shift_d = 8'h3A;
          else if (char_idx_q == CR_IDX)
            shift_d = 8'h0D;
          else
            shift_d = 8'h0A;
          tx_d    = 1'b0;
          state_d = START_BIT;
        end
      end
      WAIT_RAM: begin
        if (wait_q) begin
          shift_d = ram_q;
          tx_d    = 1'b0;
          state_d = START_BIT;
        end else begin
          wait_d = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA_BITS;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (char_idx_q == LF_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            char_idx_d = char_idx_q + 9'd1;
            state_d    = FETCH;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        ram_address_d = 8'h00;
        char_idx_d    = 9'd0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      char_idx_q    <= 9'd0;
      bit_cnt_q     <= '0;
      bit_idx_q     <= 3'd0;
      wait_q        <= 1'b0;
      shift_q       <= 8'h00;
      key_q         <= 22'd0;
      ram_address_q <= 8'h00;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      char_idx_q    <= char_idx_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      wait_q        <= wait_d;
      shift_q       <= shift_d;
      key_q         <= key_d;
      ram_address_q <= ram_address_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ram_address = ram_address_q;
  assign uart_tx     = tx_q;
  assign busy        = busy_q;
  assign done_dump   = done_q;

endmodule

// File: tb/tb_message_dumper.sv
// Scoreboard bench: expected characters are queued at each accepted request and a
// UART receiver process decodes uart_tx and compares against the queue.
module tb_message_dumper;

  localparam int MSG_LEN  = 256;
  localparam int CPB      = 5;
  localparam int CHAR_CYC = 10 * CPB;
  localparam int FRAME_BOUND = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_dump = 1'b0;
  logic [21:0] secret_key = 22'd0;
  logic [7:0]  ram_address;
  logic [7:0]  ram_q = 8'h00;
  logic        uart_tx;
  logic        busy;
  logic        done_dump;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;
  byte unsigned expQ[$];
  int doneExpected = 0;
  int doneCount = 0;

  int cycle = 0;
  int rxActive = 0;
  int rxCycle = 0;
  int rxCharNo = 0;
  int lastStart = 0;
  logic prevTx = 1'b1;
  logic rxGlitch = 1'b0;
  logic [9:0] rxBits = '0;

  message_dumper #(.MSG_LEN(MSG_LEN), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .start_dump(start_dump),
    .secret_key(secret_key),
    .ram_address(ram_address),
    .ram_q(ram_q),
    .uart_tx(uart_tx),
    .busy(busy),
    .done_dump(done_dump)
  );

  always #5 clk = ~clk;

  // RAM read data is available to be sampled on the second edge after the address moves
  always @(posedge clk) ram_q <= mem[ram_address];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference frame: key printed as 24-bit uppercase hex, colon, RAM bytes, CR LF
  task automatic pushFrame(input logic [21:0] key);
    string h;
    h = $sformatf("%h", {2'b00, key});
    h = h.toupper();
    for (int i = 0; i < 6; i++) expQ.push_back(h[i]);
    expQ.push_back(8'h3A);
    for (int a = 0; a < MSG_LEN; a++) expQ.push_back(mem[a]);
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
    doneExpected++;
  endtask

  // mode 0: byte equals address, 1: random, 2: all 'z'
  task automatic applyStimulus(input logic [21:0] key, input int mode);
    for (int a = 0; a < 256; a++) begin
      if (mode == 0) mem[a] = 8'(a);
      else if (mode == 1) mem[a] = 8'($urandom_range(0, 255));
      else mem[a] = 8'h7A;
    end
    secret_key = key;
  endtask

  task automatic startFrame(input string name);
    start_dump = 1'b1;
    @(posedge clk);
    #1;
    start_dump = 1'b0;
    checkOutput({name, "_busy_rise"}, busy, 1);
    pushFrame(secret_key);
  endtask

  task automatic waitDone(input string name);
    int c;
    for (c = 0; c < FRAME_BOUND; c++) begin
      @(posedge clk);
      #1;
      if (done_dump) break;
    end
    checkOutput({name, "_done_seen"}, done_dump, 1);
    checkOutput({name, "_busy_at_done"}, busy, 0);
  endtask

  task automatic waitChars(input int n, input string name);
    for (int c = 0; c < FRAME_BOUND && rxCharNo < n; c++) @(posedge clk);
    checkOutput({name, "_reached"}, rxCharNo, n);
  endtask

  // UART receiver: checks framing, bit duration, character spacing and content
  always @(negedge clk) begin
    cycle++;
    if (!reset) begin
      rxActive = 0;
      rxCharNo = 0;
      doneExpected = 0;
      expQ.delete();
      prevTx = 1'b1;
    end else begin
      if (done_dump) begin
        doneCount++;
        checkOutput("done_pending_chars", expQ.size(), 0);
        checkOutput("done_expected", (doneExpected > 0) ? 1 : 0, 1);
        if (doneExpected > 0) doneExpected--;
        rxCharNo = 0;
      end
      if (rxActive == 0 && prevTx && !uart_tx) begin
        if (rxCharNo > 0)
          checkOutput($sformatf("gap_char%0d", rxCharNo), cycle - lastStart,
                      CHAR_CYC + ((rxCharNo >= 7 && rxCharNo < 7 + MSG_LEN) ? 3 : 1));
        lastStart = cycle;
        rxActive = 1;
        rxCycle = 0;
        rxGlitch = 1'b0;
      end
      if (rxActive != 0) begin
        if (rxCycle % CPB == 0) rxBits[rxCycle / CPB] = uart_tx;
        else if (uart_tx !== rxBits[rxCycle / CPB]) rxGlitch = 1'b1;
        rxCycle++;
        if (rxCycle == CHAR_CYC) begin
          rxActive = 0;
          checkOutput($sformatf("framing_char%0d", rxCharNo),
                      {rxGlitch, rxBits[0], rxBits[9]}, 3'b001);
          if (expQ.size() == 0) begin
            checkOutput($sformatf("unexpected_char%0d", rxCharNo), rxBits[8:1], 9'h100);
          end else begin
            checkOutput($sformatf("char%0d", rxCharNo), rxBits[8:1], expQ.pop_front());
          end
          rxCharNo++;
        end
      end
      prevTx = uart_tx;
    end
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_uart_tx", uart_tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done_dump, 0);
    checkOutput("reset_ram_address", ram_address, 0);
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: address-pattern RAM, re-pulses and key changes mid-frame are ignored
    applyStimulus(22'h3FFFFF, 0);
    reset = 1'b1;
    startFrame("f1");
    waitChars(3, "f1_char3");
    start_dump = 1'b1;
    secret_key = 22'($urandom);
    @(posedge clk);
    #1;
    start_dump = 1'b0;
    waitChars(20, "f1_char20");
    start_dump = 1'b1;
    secret_key = 22'($urandom);
    @(posedge clk);
    #1;
    start_dump = 1'b0;
    checkOutput("f1_busy_mid", busy, 1);
    waitDone("f1");

    // A request during the done cycle is dropped; one cycle later it is taken
    applyStimulus(22'($urandom), 1);
    start_dump = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("f1_done_single", done_dump, 0);
    checkOutput("f1_start_at_done_ignored", busy, 0);
    checkOutput("f1_idle_ram_address", ram_address, 0);
    startFrame("f2");
    waitDone("f2");
    @(posedge clk);
    #1;

    // Frame 3: aborted by reset during data bits of character 10
    applyStimulus(22'($urandom), 1);
    startFrame("f3");
    for (int c = 0; c < FRAME_BOUND; c++) begin
      @(posedge clk);
      if (rxCharNo == 10 && rxActive != 0 && rxCycle > CPB && rxCycle < 9 * CPB) break;
    end
    checkOutput("f3_reached_char10", rxCharNo, 10);
    #2 reset = 1'b0;
    #1;
    checkOutput("f3_abort_uart_tx", uart_tx, 1);
    checkOutput("f3_abort_busy", busy, 0);
    checkOutput("f3_abort_ram_address", ram_address, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("f3_abort_no_done", done_dump, 0);

    // Frame 4: request presented right as reset releases
    applyStimulus(22'h000249, 2);
    reset = 1'b1;
    startFrame("f4");
    waitDone("f4");

    repeat (60) @(posedge clk);
    #1;
    checkOutput("end_queue_empty", expQ.size(), 0);
    checkOutput("end_done_count", doneCount, 3);
    checkOutput("end_uart_idle", uart_tx, 1);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_ram_address", ram_address, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/message_dumper.md
MESSAGE_DUMPER -- requirements
Module: message_dumper

Interface
REQ-001 Parameter MSG_LEN, default 32: number of decrypted bytes read and sent (1..256).
REQ-002 Parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200 baud), minimum 2.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; one clock domain, no other clock.
REQ-005 start_dump  input  1  single-cycle request to transmit one frame.
REQ-006 secret_key  input  22  key found by the key search; sampled at accept.
REQ-007 ram_address  output  8  read address to decrypted_ram port (wren tied low externally).
REQ-008 ram_q  input  8  decrypted_ram read data, valid on the 2nd rising edge after ram_address changes.
REQ-009 uart_tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-010 busy  output  1  high from the accept cycle until done_dump.
REQ-011 done_dump  output  1  single-cycle pulse after the last stop bit of the frame.

Function
REQ-012 The frame SHALL be sent in this order: 6 ASCII uppercase hex digits of {2'b00, secret_key}, MSB nibble first; 0x3A (':'); decrypted bytes at addresses 0..MSG_LEN-1 in order; 0x0D; 0x0A. With defaults, 41 characters.
REQ-013 Hex digits SHALL map 0-9 to 0x30-0x39 and A-F to 0x41-0x46.
REQ-014 start_dump SHALL be accepted only in IDLE; while busy it SHALL be ignored, with no queueing.
REQ-015 On accept, secret_key SHALL be latched; later changes SHALL NOT affect the frame in progress.
REQ-016 States: IDLE, FETCH, WAIT_RAM, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-017 IDLE -> FETCH on accept. FETCH selects the next character.
REQ-018 For a message byte, FETCH SHALL drive ram_address and go to WAIT_RAM. WAIT_RAM SHALL last 2 cycles, then latch ram_q into the shift register.
REQ-019 For header and trailer characters, FETCH SHALL go directly to START_BIT with the character loaded.
REQ-020 START_BIT SHALL hold uart_tx=0 for CLKS_PER_BIT cycles.
REQ-021 DATA_BITS SHALL output bit 0 first, each bit for CLKS_PER_BIT cycles, 8 bits.
REQ-022 STOP_BIT SHALL hold uart_tx=1 for CLKS_PER_BIT cycles, then go to FETCH, or to DONE after 0x0A.
REQ-023 DONE SHALL assert done_dump for exactly one cycle and return to IDLE. busy SHALL deassert in that same cycle.
REQ-024 The bit-time counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL restart at every bit boundary with no cumulative drift. Frame length SHALL be exactly (9+MSG_LEN) x 10 x CLKS_PER_BIT cycles plus fetch overhead.
REQ-025 Message index SHALL count 0..MSG_LEN-1 with no wrap into header or trailer. MSG_LEN=256 SHALL address 0..255 without overflowing the terminal compare (counter 9 bits).
REQ-026 ram_address SHALL hold its value outside FETCH/WAIT_RAM. Its value in IDLE is 0.
REQ-027 A start_dump coinciding with done_dump SHALL be ignored. A new request is accepted from the following IDLE cycle.

Reset
REQ-028 While reset=0, asynchronously: state=IDLE, uart_tx=1, busy=0, done_dump=0, ram_address=0, all counters and the key latch cleared.
REQ-029 Reset mid-frame SHALL abort the frame immediately, with uart_tx high in the same cycle reset falls. No done_dump SHALL be produced.
REQ-030 After reset release, the block SHALL accept start_dump on the first clk edge.

Verification
REQ-031 CLKS_PER_BIT=4, MSG_LEN=2, key=22'h3FFFFF, RAM {0x61,0x20}, pulse start -> line decodes "3FFFFF:a \r\n". done_dump occurs once, 11 chars later.
REQ-032 Key=22'h000249, defaults, RAM filled with 0x7A -> header "000249:", then 32 x 'z', then CR LF. Each bit is exactly 434 cycles (check start-bit falling edge to falling edge).
REQ-033 start_dump re-pulsed at chars 3 and 20, and secret_key changed mid-frame -> a single unchanged frame and a single done_dump.
REQ-034 reset asserted during DATA_BITS of char 10 -> uart_tx=1 and busy=0 immediately, no done_dump. A new start afterwards yields a complete correct frame.
REQ-035 RAM model with 2-cycle latency, MSG_LEN=256, addresses holding pattern addr[7:0] -> bytes 0x00..0xFF sent in order. ram_address never exceeds 0xFF and is stable during each WAIT_RAM.
REQ-036 start_dump in the same cycle as done_dump -> ignored. A pulse one cycle later -> accepted, busy rises.
